// File: rtl/decode_stage_hz.sv
// Decode stage with register file, bypassed reads, load-use bubble insertion and ID/EX register.
// Optional stall/flush event counters are compiled in with DECODE_PERF_CNT_EN.
module decode_stage_hz #(
  parameter int DATA_W  = 24,
  parameter int INSTR_W = 34,
  parameter int NREGS   = 32,
  parameter int OP_W    = 4,
  localparam int REG_AW = $clog2(NREGS),
  localparam int IMM_W  = INSTR_W - OP_W - 3*REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidD,
  input  logic [INSTR_W-1:0] InstrD,
  input  logic [DATA_W-1:0] PCD,
  input  logic [DATA_W-1:0] PCPlus4D,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RDW,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              FlushE,
  input  logic              HoldE,
  output logic              StallD,
  output logic              ValidE,
  output logic              RegWriteE,
  output logic              ALUSrcE,
  output logic              MemWriteE,
  output logic              ResultSrcE,
  output logic              BranchE,
  output logic [2:0]        ALUControlE,
  output logic [DATA_W-1:0] RD1_E,
  output logic [DATA_W-1:0] RD2_E,
  output logic [DATA_W-1:0] Imm_Ext_E,
  output logic [REG_AW-1:0] RS1_E,
  output logic [REG_AW-1:0] RS2_E,
  output logic [REG_AW-1:0] RD_E,
  output logic [DATA_W-1:0] PCE,
  output logic [DATA_W-1:0] PCPlus4E
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt
`endif
);

  // Control word layout: {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl[2:0]}
  function automatic logic [7:0] decode_ctrl(input logic [OP_W-1:0] op);
    case (op)
      OP_W'(1):  return 8'b1000_0000;
      OP_W'(2):  return 8'b1000_0001;
      OP_W'(3):  return 8'b1000_0010;
      OP_W'(4):  return 8'b1000_0011;
      OP_W'(5):  return 8'b1000_0101;
      OP_W'(6):  return 8'b1100_0000;
      OP_W'(7):  return 8'b1101_0000;
      OP_W'(8):  return 8'b0110_0000;
      OP_W'(9):  return 8'b0000_1001;
      default:   return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] sext_imm(input logic signed [IMM_W-1:0] imm);
    logic signed [DATA_W-1:0] s;
    s = imm;
    return s;
  endfunction

`ifdef DECODE_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction
`endif

  logic [OP_W-1:0]   w_op;
  logic [REG_AW-1:0] w_rd, w_rs1, w_rs2;
  logic [IMM_W-1:0]  w_imm;
  logic [7:0]        w_ctrl;
  logic [DATA_W-1:0] w_rd1, w_rd2;
  logic              w_wb_hit;

  logic [DATA_W-1:0] r_rf [NREGS];

  logic              r_vld_p1;
  logic [7:0]        r_ctrl_p1;
  logic [DATA_W-1:0] r_rd1_p1, r_rd2_p1, r_imm_p1, r_pc_p1, r_pc4_p1;
  logic [REG_AW-1:0] r_rs1_p1, r_rs2_p1, r_rd_p1;

  assign w_op   = InstrD[INSTR_W-1 -: OP_W];
  assign w_rd   = InstrD[INSTR_W-OP_W-1 -: REG_AW];
  assign w_rs1  = InstrD[INSTR_W-OP_W-REG_AW-1 -: REG_AW];
  assign w_rs2  = InstrD[IMM_W +: REG_AW];
  assign w_imm  = InstrD[IMM_W-1:0];
  assign w_ctrl = ValidD ? decode_ctrl(w_op) : 8'd0;
  assign w_wb_hit = RegWriteW && (RDW != '0);

  // Writeback data is forwarded so an instruction never reads a value one cycle stale.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (w_wb_hit && RDW == w_rs1) w_rd1 = ResultW;
    else if (w_rs1 != '0)         w_rd1 = r_rf[w_rs1];
    if (w_wb_hit && RDW == w_rs2) w_rd2 = ResultW;
    else if (w_rs2 != '0)         w_rd2 = r_rf[w_rs2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (w_wb_hit) begin
      r_rf[RDW] <= ResultW;
    end
  end

  assign StallD = !rst && r_vld_p1 && r_ctrl_p1[4] && (r_rd_p1 != '0) && ValidD &&
                  ((r_rd_p1 == w_rs1) || (r_rd_p1 == w_rs2)) && !FlushE;

  // ID/EX boundary: flush beats hold, hold beats the load-use bubble.
  always_ff @(posedge clk) begin
    if (rst || FlushE || (!HoldE && StallD)) begin
      r_vld_p1  <= 1'b0;
      r_ctrl_p1 <= '0;
      r_rd1_p1  <= '0;
      r_rd2_p1  <= '0;
      r_imm_p1  <= '0;
      r_rs1_p1  <= '0;
      r_rs2_p1  <= '0;
      r_rd_p1   <= '0;
      r_pc_p1   <= '0;
      r_pc4_p1  <= '0;
    end else if (!HoldE) begin
      r_vld_p1  <= ValidD;
      r_ctrl_p1 <= w_ctrl;
      r_rd1_p1  <= w_rd1;
      r_rd2_p1  <= w_rd2;
      r_imm_p1  <= sext_imm(w_imm);
      r_rs1_p1  <= w_rs1;
      r_rs2_p1  <= w_rs2;
      r_rd_p1   <= w_rd;
      r_pc_p1   <= PCD;
      r_pc4_p1  <= PCPlus4D;
    end
  end

  assign ValidE      = r_vld_p1;
  assign RegWriteE   = r_ctrl_p1[7];
  assign ALUSrcE     = r_ctrl_p1[6];
  assign MemWriteE   = r_ctrl_p1[5];
  assign ResultSrcE  = r_ctrl_p1[4];
  assign BranchE     = r_ctrl_p1[3];
  assign ALUControlE = r_ctrl_p1[2:0];
  assign RD1_E       = r_rd1_p1;
  assign RD2_E       = r_rd2_p1;
  assign Imm_Ext_E   = r_imm_p1;
  assign RS1_E       = r_rs1_p1;
  assign RS2_E       = r_rs2_p1;
  assign RD_E        = r_rd_p1;
  assign PCE         = r_pc_p1;
  assign PCPlus4E    = r_pc4_p1;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallD && !HoldE) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (FlushE)           r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;
`endif

endmodule
